wb_arbiter_rr: RTL and testbench

Parametrised Wishbone arbiter connecting `N_MASTERS` bus masters (interpreter, core, debug/DMA engines) to a single slave port. Arbitration is round-robin with a registered one-hot grant held for a complete transaction (request through slave ack). An optional watchdog terminates hung transactions. The block sits between the masters and the memory/peripheral interconnect.

---
 rtl/wb_arbiter_rr.sv | 170 +++++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: N_MASTERS masters share one slave port.
// A registered one-hot grant is held from request until slave ack, master
// abort or watchdog expiry. Optional watchdog enabled by WB_ARB_TIMEOUT_EN.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                                  Clk,
  input  logic                                  Rst,
  input  logic [N_MASTERS-1:0][`ADDR_SIZE-1:0]  Wb_addr_m,
  input  logic [N_MASTERS-1:0]                  Wb_cs_m,
  input  logic [N_MASTERS-1:0]                  Wb_we_m,
  input  logic [N_MASTERS-1:0][`WORD_SIZE-1:0]  Wb_wdata_m,
  output logic [N_MASTERS-1:0][`WORD_SIZE-1:0]  Wb_rdata_m,
  output logic [N_MASTERS-1:0]                  Wb_ack_m,
  output logic [`ADDR_SIZE-1:0]                 Wb_addr,
  output logic                                  Wb_cs,
  output logic                                  Wb_we,
  output logic [`WORD_SIZE-1:0]                 Wb_wdata,
  input  logic [`WORD_SIZE-1:0]                 Wb_rdata,
  input  logic                                  Wb_ack,
  output logic [N_MASTERS-1:0]                  Grant,
  output logic                                  Busy,
  output logic                                  Timeout
);

  localparam int PTR_W = $clog2(N_MASTERS);
  localparam logic [PTR_W:0]   N_W  = (PTR_W+1)'(N_MASTERS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_MASTERS - 1);

  if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n_masters
    $error("wb_arbiter_rr: N_MASTERS must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter_rr: TIMEOUT must be in 1..65535");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic                   busy;
  logic                   fire;
  logic                   any_req;
  logic [PTR_W-1:0]       win_idx;
  logic                   sel_cs;
  logic                   sel_we;
  logic [`ADDR_SIZE-1:0]  sel_addr;
  logic [`WORD_SIZE-1:0]  sel_wdata;

  assign busy = (state_q == BUSY);

  // Round-robin pick: rotate requests so ptr sits at bit 0, take lowest set bit.
  always_comb begin
    logic [2*N_MASTERS-1:0] rot;
    logic [PTR_W-1:0]       off;
    logic [PTR_W:0]         sum;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    rot     = {Wb_cs_m, Wb_cs_m} >> ptr_q;
    off     = '0;
    any_req = |Wb_cs_m;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (rot[k]) off = PTR_W'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    win_idx = sum[PTR_W-1:0];
  end

  // Granted master's request fields; grant is one-hot and all-zero in IDLE.
  always_comb begin
    sel_cs    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        sel_cs    = sel_cs    | Wb_cs_m[i];
        sel_we    = sel_we    | Wb_we_m[i];
        sel_addr  = sel_addr  | Wb_addr_m[i];
        sel_wdata = sel_wdata | Wb_wdata_m[i];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;

  // Watchdog fires on the TIMEOUT-th un-acked BUSY cycle; a same-cycle ack wins.
  assign fire = busy && sel_cs && !Wb_ack && (cnt_q == CNT_LAST);

  // Count un-acked BUSY cycles; held at zero in IDLE so it starts fresh.
  always_comb begin
    cnt_d = '0;
    if (busy && !Wb_ack) cnt_d = cnt_q + 16'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign fire = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, release on ack, abort or watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
          ptr_d   = (win_idx == LAST) ? '0 : win_idx + PTR_W'(1);
        end
      end
      BUSY: begin
        if (Wb_ack || !sel_cs || fire) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Return path: only the granted master sees ack/rdata; watchdog supplies all-ones.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      Wb_ack_m[i]   = grant_q[i] & (Wb_ack | fire);
      Wb_rdata_m[i] = !grant_q[i] ? '0 : (fire ? '1 : Wb_rdata);
    end
  end

  assign Wb_cs    = sel_cs & ~fire;
  assign Wb_we    = sel_we;
  assign Wb_addr  = sel_addr;
  assign Wb_wdata = sel_wdata;
  assign Grant    = grant_q;
  assign Busy     = busy;
  assign Timeout  = fire;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr (N_MASTERS=4, TIMEOUT=4).
// Expected master completions are queued when the slave response is driven
// and compared by a monitor when a master ack appears.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_wb_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = `ADDR_SIZE;
  localparam int DW = `WORD_SIZE;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0][AW-1:0] addr_m;
  logic [N-1:0]         cs_m;
  logic [N-1:0]         we_m;
  logic [N-1:0][DW-1:0] wdata_m;
  logic [N-1:0][DW-1:0] rdata_m;
  logic [N-1:0]         ack_m;
  logic [AW-1:0]        wb_addr;
  logic                 wb_cs;
  logic                 wb_we;
  logic [DW-1:0]        wb_wdata;
  logic [DW-1:0]        wb_rdata;
  logic                 wb_ack;
  logic [N-1:0]         grant;
  logic                 busy;
  logic                 tmo;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int            m;
    logic [DW-1:0] d;
    logic          to;
  } exp_t;

  exp_t exp_q[$];

  wb_arbiter_rr #(.N_MASTERS(N), .TIMEOUT(4)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .Wb_addr_m  (addr_m),
    .Wb_cs_m    (cs_m),
    .Wb_we_m    (we_m),
    .Wb_wdata_m (wdata_m),
    .Wb_rdata_m (rdata_m),
    .Wb_ack_m   (ack_m),
    .Wb_addr    (wb_addr),
    .Wb_cs      (wb_cs),
    .Wb_we      (wb_we),
    .Wb_wdata   (wb_wdata),
    .Wb_rdata   (wb_rdata),
    .Wb_ack     (wb_ack),
    .Grant      (grant),
    .Busy       (busy),
    .Timeout    (tmo)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b1);
  endtask

  // Scoreboard monitor: every master ack must match the next queued completion.
  exp_t                 e_mon;
  logic [N-1:0][DW-1:0] er;
  always @(negedge clk) begin
    if (!rst && ack_m != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", ack_m, '0);
      end else begin
        e_mon = exp_q.pop_front();
        er = '0;
        er[e_mon.m] = e_mon.d;
        check("sb_ack_m", ack_m, 256'(1) << e_mon.m);
        check("sb_rdata_m", rdata_m, er);
        check("sb_timeout", tmo, e_mon.to);
        check("sb_wb_cs", wb_cs, !e_mon.to);
      end
    end
  end

  initial begin
    int bad;
    cs_m     = '0;
    we_m     = '0;
    addr_m   = '0;
    wdata_m  = '0;
    wb_rdata = '0;
    wb_ack   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_cs", wb_cs, 1'b0);
    check("rst_timeout", tmo, 1'b0);
    check("rst_ack_m", ack_m, '0);
    rst = 1'b0;

    // Master 1 write, then reset mid-BUSY
    cs_m[1]    = 1'b1;
    addr_m[1]  = 32'h20;
    we_m[1]    = 1'b1;
    wdata_m[1] = 32'h1234;
    tick();
    check("wr_grant", grant, 4'b0010);
    check("wr_we", wb_we, 1'b1);
    check("wr_addr", wb_addr, 32'h20);
    check("wr_wdata", wb_wdata, 32'h1234);
    tick();
    rst      = 1'b1;
    wb_ack   = 1'b1;
    wb_rdata = 32'hCAFE;
    #1;
    check("midrst_grant", grant, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cs", wb_cs, 1'b0);
    check("midrst_ack_m", ack_m, '0);
    check("midrst_rdata_m", rdata_m, '0);
    tick();
    rst      = 1'b0;
    wb_ack   = 1'b0;
    wb_rdata = '0;
    tick();
    check("regrant_grant", grant, 4'b0010);
    check("regrant_busy", busy, 1'b1);
    exp_q.push_back('{m: 1, d: 32'h11112222, to: 1'b0});
    wb_rdata = 32'h11112222;
    wb_ack   = 1'b1;
    tick();
    wb_ack   = 1'b0;
    wb_rdata = '0;
    cs_m[1]  = 1'b0;
    we_m[1]  = 1'b0;
    check("regrant_done", busy, 1'b0);

    // Single read by master 0, slave acks in the third BUSY cycle
    cs_m[0]   = 1'b1;
    addr_m[0] = 32'h10;
    wait_busy("rd_busy");
    check("rd_grant", grant, 4'b0001);
    check("rd_addr", wb_addr, 32'h10);
    check("rd_we", wb_we, 1'b0);
    check("rd_cs", wb_cs, 1'b1);
    tick();
    tick();
    check("rd_stall_busy", busy, 1'b1);
    check("rd_stall_ack_m", ack_m, '0);
    exp_q.push_back('{m: 0, d: 32'hA5A5A5A5, to: 1'b0});
    wb_rdata = 32'hA5A5A5A5;
    wb_ack   = 1'b1;
    #1;
    check("rd_m1_rdata", rdata_m[1], '0);
    check("rd_m1_ack", ack_m[1], 1'b0);
    tick();
    wb_ack   = 1'b0;
    wb_rdata = '0;
    cs_m[0]  = 1'b0;
    check("rd_done_busy", busy, 1'b0);
    check("rd_done_grant", grant, '0);

    // Reset in IDLE to restart the pointer at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin: all four request continuously, one-cycle slave
    for (int i = 0; i < N; i++) addr_m[i] = AW'(32'h100 + i);
    cs_m = '1;
    for (int k = 0; k < 5; k++) begin
      wait_busy("rr_busy");
      check("rr_grant", grant, 256'(1) << (k % N));
      check("rr_addr", wb_addr, 32'h100 + (k % N));
      exp_q.push_back('{m: k % N, d: DW'(32'hB0000000 + k), to: 1'b0});
      wb_rdata = DW'(32'hB0000000 + k);
      wb_ack   = 1'b1;
      tick();
      wb_ack   = 1'b0;
      wb_rdata = '0;
      if (k == 4) cs_m = '0;
      check("rr_idle_gap", busy, 1'b0);
    end

    // Abort by master 2, then a late slave ack in IDLE
    cs_m[2]   = 1'b1;
    addr_m[2] = 32'h300;
    wait_busy("ab_busy");
    check("ab_grant", grant, 4'b0100);
    cs_m[2] = 1'b0;
    #1;
    check("ab_cs_drop", wb_cs, 1'b0);
    tick();
    check("ab_busy_clr", busy, 1'b0);
    check("ab_grant_clr", grant, '0);
    wb_ack   = 1'b1;
    wb_rdata = 32'hDEAD;
    #1;
    check("ab_late_ack_m", ack_m, '0);
    check("ab_late_rdata_m", rdata_m, '0);
    tick();
    wb_ack   = 1'b0;
    wb_rdata = '0;

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog fires on the 4th BUSY cycle
    cs_m[3]   = 1'b1;
    addr_m[3] = 32'h400;
    wait_busy("to_busy");
    check("to_grant", grant, 4'b1000);
    check("to_c1", tmo, 1'b0);
    tick();
    check("to_c2", tmo, 1'b0);
    tick();
    check("to_c3", tmo, 1'b0);
    exp_q.push_back('{m: 3, d: '1, to: 1'b1});
    tick();
    check("to_pulse", tmo, 1'b1);
    check("to_cs_forced", wb_cs, 1'b0);
    tick();
    cs_m[3] = 1'b0;
    check("to_after_busy", busy, 1'b0);
    check("to_after_pulse", tmo, 1'b0);

    // Ack in the same cycle the watchdog would fire wins
    cs_m[3] = 1'b1;
    wait_busy("tw_busy");
    tick();
    tick();
    tick();
    exp_q.push_back('{m: 3, d: 32'h5A5A0001, to: 1'b0});
    wb_rdata = 32'h5A5A0001;
    wb_ack   = 1'b1;
    #1;
    check("tw_no_pulse", tmo, 1'b0);
    tick();
    wb_ack   = 1'b0;
    wb_rdata = '0;
    cs_m[3]  = 1'b0;
    check("tw_done", busy, 1'b0);
`else
    // Long stall: no watchdog, BUSY held until the ack
    cs_m[3]   = 1'b1;
    addr_m[3] = 32'h400;
    wait_busy("st_busy");
    check("st_grant", grant, 4'b1000);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (busy !== 1'b1 || tmo !== 1'b0) bad++;
      tick();
    end
    check("st_bad_cycles", bad, 0);
    check("st_still_busy", busy, 1'b1);
    exp_q.push_back('{m: 3, d: 32'h0BADF00D, to: 1'b0});
    wb_rdata = 32'h0BADF00D;
    wb_ack   = 1'b1;
    tick();
    wb_ack   = 1'b0;
    wb_rdata = '0;
    cs_m[3]  = 1'b0;
    check("st_done", busy, 1'b0);
`endif

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
